// File: rtl/game_countdown_timer.sv
// Round countdown timer: 1 Hz prescaler, load/pause/bonus/expiry control and
// low-time/blink flags for the HUD mm:ss display.
module game_countdown_timer #(
   parameter int unsigned TICKS_PER_SEC = 25_000_000,
   parameter int unsigned MAX_SECONDS   = 1199,
   parameter int unsigned LOW_THRESHOLD = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [10:0] initial_time,
   input  logic        pause,
   input  logic        add_time,
   input  logic [7:0]  add_amount,
   output logic [10:0] timeInSeconds,
   output logic        running,
   output logic        time_up,
   output logic        low_time,
   output logic        blink
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [PW-1:0] PRE_HALF = PW'(TICKS_PER_SEC / 2);
   localparam logic [11:0]   MAX12    = 12'(MAX_SECONDS);
   localparam logic [10:0]   MAX11    = 11'(MAX_SECONDS);
   localparam logic [10:0]   LOW11    = 11'(LOW_THRESHOLD);

   typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED, S_EXPIRED} state_t;

   state_t        state_q, state_d;
   logic [10:0]   secs_q, secs_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          run_q, tu_q, low_q, blink_q;
   logic          tu_d, low_d, blink_d;

   logic          tick, add_en;
   logic [11:0]   adj;
   logic [10:0]   secs_upd, load_val;

   // A tick is only honoured when not pausing; a paused wrap is deferred, not lost.
   assign tick     = (state_q == S_RUNNING) && !pause && (pre_q == PRE_LAST);
   assign add_en   = add_time && ((state_q == S_RUNNING) || (state_q == S_PAUSED));
   assign adj      = {1'b0, secs_q} + (add_en ? {4'd0, add_amount} : 12'd0) - {11'd0, tick};
   assign secs_upd = (adj > MAX12) ? MAX11 : adj[10:0];
   assign load_val = (initial_time > MAX11) ? MAX11 : initial_time;

   always_comb begin
      state_d = state_q;
      secs_d  = secs_q;
      pre_d   = pre_q;
      tu_d    = 1'b0;
      if (start) begin
         secs_d = load_val;
         pre_d  = '0;
         if (load_val == 11'd0) begin
            state_d = S_EXPIRED;
            tu_d    = 1'b1;
         end else begin
            state_d = S_RUNNING;
         end
      end else begin
         case (state_q)
            S_RUNNING: begin
               secs_d = secs_upd;
               if (pause) begin
                  state_d = S_PAUSED;
               end else begin
                  pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
                  if (tick && (secs_upd == 11'd0)) begin
                     state_d = S_EXPIRED;
                     tu_d    = 1'b1;
                  end
               end
            end
            S_PAUSED: begin
               secs_d = secs_upd;
               if (!pause) state_d = S_RUNNING;
            end
            default: ;
         endcase
      end
      low_d   = ((state_d == S_RUNNING) || (state_d == S_PAUSED)) &&
                (secs_d != 11'd0) && (secs_d <= LOW11);
      blink_d = low_d && (pre_d < PRE_HALF);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         secs_q  <= '0;
         pre_q   <= '0;
         run_q   <= 1'b0;
         tu_q    <= 1'b0;
         low_q   <= 1'b0;
         blink_q <= 1'b0;
      end else begin
         state_q <= state_d;
         secs_q  <= secs_d;
         pre_q   <= pre_d;
         run_q   <= (state_d == S_RUNNING);
         tu_q    <= tu_d;
         low_q   <= low_d;
         blink_q <= blink_d;
      end
   end

   assign timeInSeconds = secs_q;
   assign running       = run_q;
   assign time_up       = tu_q;
   assign low_time      = low_q;
   assign blink         = blink_q;

endmodule
